// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle 16-bit-instruction CPU with req/ack instruction and
// data memory ports, a HALT instruction, registered {V,C,N,Z} flags and a
// combinational debug read port onto the eight-entry register file.
//
// Optional feature macro: CPU_FLAG_REG_EN
//   defined   -> branches test the registered flags (Z=flags[0], N=flags[1])
//   undefined -> branches test the branch's own ALU evaluation of R[SA]
//
// Handshake rule for both memory ports: a request stays high, with its
// address/data/we held stable, until the cycle in which ack is sampled high;
// the transfer completes on that rising edge. Ack is ignored in any cycle
// where the matching request is low.
module cpu_mc #(
  parameter int              DW     = 8,
  parameter int              PCW    = 8,
  parameter logic [PCW-1:0]  RST_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic [15:0]    imem_rdata,
  input  logic           imem_ack,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic           dmem_ack,
  output logic [PCW-1:0] pc,
  output logic [1:0]     state,
  output logic           halted,
  output logic [3:0]     flags,
  input  logic [2:0]     dbg_sel,
  output logic [DW-1:0]  dbg_data
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int XW = (DW > PCW) ? DW : PCW;

  state_t          cur_state, nxt_state;
  logic [15:0]     ir;
  logic [DW-1:0]   regs [8];

  // Decode fields and control bits of the latched instruction
  logic [2:0]      dr, sa, sb;
  logic            mb, md, rw, mw, pl, jb, bc, is_halt;
  logic [3:0]      fs;
  logic [DW-1:0]   const_val;
  logic signed [5:0] ad6;
  logic [PCW-1:0]  ad;

  assign dr        = ir[8:6];
  assign sa        = ir[5:3];
  assign sb        = ir[2:0];
  assign mb        = ir[15];
  assign md        = ir[13];
  assign rw        = ~ir[14];
  assign mw        = ir[14] & ~ir[15];
  assign pl        = ir[15] & ir[14];
  assign jb        = ir[13];
  assign bc        = ir[9];
  assign fs        = {ir[12], ir[11], ir[10], ir[9] & ~pl};
  assign is_halt   = (ir[15:9] == 7'h7F);
  assign const_val = DW'(ir[2:0]);
  assign ad6       = {ir[8:6], ir[2:0]};
  assign ad        = PCW'(ad6);

  // ALU operands
  logic [DW-1:0]   alu_a, alu_b, alu_y, alu_f;
  logic [DW:0]     alu_sum;
  logic            alu_cin, alu_v, alu_c, alu_n, alu_z;

  assign alu_a = regs[sa];
  assign alu_b = mb ? const_val : regs[sb];

  // ALU: the lower eight codes share one adder (A + Y + cin); the upper
  // eight are logic/shift ops with V and C forced to zero.
  always_comb begin
    alu_y   = '0;
    alu_cin = 1'b0;
    case (fs[2:0])
      3'b000: begin alu_y = '0;     alu_cin = 1'b0; end
      3'b001: begin alu_y = '0;     alu_cin = 1'b1; end
      3'b010: begin alu_y = alu_b;  alu_cin = 1'b0; end
      3'b011: begin alu_y = alu_b;  alu_cin = 1'b1; end
      3'b100: begin alu_y = ~alu_b; alu_cin = 1'b0; end
      3'b101: begin alu_y = ~alu_b; alu_cin = 1'b1; end
      3'b110: begin alu_y = '1;     alu_cin = 1'b0; end
      default: begin alu_y = '1;    alu_cin = 1'b1; end
    endcase
    alu_sum = {1'b0, alu_a} + {1'b0, alu_y} + {{DW{1'b0}}, alu_cin};
    alu_f   = alu_sum[DW-1:0];
    alu_c   = alu_sum[DW];
    alu_v   = (alu_a[DW-1] == alu_y[DW-1]) && (alu_f[DW-1] != alu_a[DW-1]);
    if (fs[3]) begin
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (fs[2:0])
        3'b000:  alu_f = alu_a & alu_b;
        3'b001:  alu_f = alu_a | alu_b;
        3'b010:  alu_f = alu_a ^ alu_b;
        3'b011:  alu_f = ~alu_a;
        3'b100:  alu_f = alu_b;
        3'b101:  alu_f = alu_b >> 1;
        3'b110:  alu_f = alu_b << 1;
        default: alu_f = alu_a;
      endcase
    end
    alu_n = alu_f[DW-1];
    alu_z = (alu_f == '0);
  end

  // Branch condition source and branch/jump targets
  logic            zb, nb, br_take;
  logic [XW-1:0]   a_ext;
  logic [PCW-1:0]  jump_pc, pc_inc;

`ifdef CPU_FLAG_REG_EN
  assign zb = flags[0];
  assign nb = flags[1];
`else
  assign zb = alu_z;
  assign nb = alu_n;
`endif

  assign br_take = (~bc & zb) | (bc & nb);
  assign a_ext   = XW'(alu_a);
  assign jump_pc = a_ext[PCW-1:0];
  assign pc_inc  = pc + PCW'(1);

  // FSM control strobes
  logic            ir_we, rf_we, flags_we;
  logic [DW-1:0]   rf_wd;
  logic [PCW-1:0]  pc_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= nxt_state;
  end

  // Next state and datapath strobes; memory-class instructions defer every
  // architectural update to the MEM state so a stalled access has no effect.
  always_comb begin
    nxt_state = cur_state;
    pc_nxt    = pc;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    rf_wd     = alu_f;
    flags_we  = 1'b0;
    case (cur_state)
      S_FETCH: begin
        if (imem_ack) begin
          ir_we     = 1'b1;
          nxt_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_halt) begin
          nxt_state = S_HALT;
        end else if (pl) begin
          pc_nxt    = jb ? jump_pc : (br_take ? pc + ad : pc_inc);
          nxt_state = S_FETCH;
        end else if (mw || (md && rw)) begin
          nxt_state = S_MEM;
        end else begin
          rf_we     = rw;
          flags_we  = rw;
          pc_nxt    = pc_inc;
          nxt_state = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          rf_we     = ~mw;
          rf_wd     = dmem_rdata;
          pc_nxt    = pc_inc;
          nxt_state = S_FETCH;
        end
      end
      default: nxt_state = S_HALT;
    endcase
  end

  // Architectural state: PC, IR, flags and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RST_PC;
      ir    <= '0;
      flags <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      pc <= pc_nxt;
      if (ir_we)    ir        <= imem_rdata;
      if (flags_we) flags     <= {alu_v, alu_c, alu_n, alu_z};
      if (rf_we)    regs[dr]  <= rf_wd;
    end
  end

  assign imem_req   = (cur_state == S_FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = (cur_state == S_MEM);
  assign dmem_we    = dmem_req & mw;
  assign dmem_addr  = alu_a;
  assign dmem_wdata = alu_b;
  assign state      = cur_state;
  assign halted     = (cur_state == S_HALT);
  assign dbg_data   = regs[dbg_sel];

endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: directed program for cpu_mc (DW=8, PCW=8, RST_PC=0). The bench
// plays both memories, predicts every PC by hand, and checks registers,
// flags, cycle counts and memory-port behaviour.
module tb_cpu_mc;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata;
  logic        dmem_ack;
  logic [7:0]  pc;
  logic [1:0]  state;
  logic        halted;
  logic [3:0]  flags;
  logic [2:0]  dbg_sel;
  logic [7:0]  dbg_data;

  cpu_mc #(.DW(8), .PCW(8), .RST_PC(8'h00)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc(pc), .state(state), .halted(halted), .flags(flags),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Opcodes (IR[15:9])
  localparam logic [6:0] OP_INC = 7'b0000001, OP_ADD = 7'b0000010, OP_SUB = 7'b0000101;
  localparam logic [6:0] OP_DEC = 7'b0000110, OP_SHR = 7'b0001101, OP_SHL = 7'b0001110;
  localparam logic [6:0] OP_LD  = 7'b0010000, OP_ST  = 7'b0100000, OP_ADI = 7'b1000010;
  localparam logic [6:0] OP_LDI = 7'b1001100, OP_BZ  = 7'b1100000, OP_BN  = 7'b1100001;
  localparam logic [6:0] OP_JMP = 7'b1110000;

`ifdef CPU_FLAG_REG_EN
  localparam logic [7:0] BZ1_PC = 8'h01;
  localparam logic [7:0] BZ2_PC = 8'hFE;
  localparam bit         BN_TAKEN = 1'b0;
`else
  localparam logic [7:0] BZ1_PC = 8'hFE;
  localparam logic [7:0] BZ2_PC = 8'h01;
  localparam bit         BN_TAKEN = 1'b1;
`endif

  // Scoreboard: expected PC after each instruction
  logic [7:0] exp_q[$];
  logic [7:0] pc_m;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         last_dreq;
  logic [7:0] d_addr, d_wdata;
  logic       d_we;

  function automatic logic [15:0] enc(input logic [6:0] op, input logic [2:0] dr,
                                      input logic [2:0] sa, input logic [2:0] sb);
    return {op, dr, sa, sb};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] idx, input logic [7:0] exp);
    @(negedge clk);
    dbg_sel = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Driver: serves one instruction word (after iwait stalled fetch cycles),
  // then services any data access with dwait stalled cycles.
  task automatic run_instr(input string tag, input logic [15:0] w, input int iwait,
                           input int dwait, input logic [7:0] rd,
                           input int exp_cyc, input logic [7:0] exp_pc);
    int guard, cyc, left;
    logic [16:0] first;
    exp_q.push_back(exp_pc);
    guard = 0;
    while (imem_req !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, ":req"}, imem_req, 1'b1);
    check({tag, ":iaddr"}, imem_addr, pc_m);
    cyc = 0;
    for (int i = 0; i < iwait; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      cyc++;
    end
    imem_rdata = w;
    imem_ack   = 1'b1;
    @(negedge clk);
    cyc++;
    imem_ack  = 1'b0;
    guard     = 0;
    last_dreq = 0;
    left      = dwait;
    first     = '0;
    while (imem_req !== 1'b1 && halted !== 1'b1 && guard < 50) begin
      if (dmem_req === 1'b1) begin
        if (last_dreq == 0) first = {dmem_we, dmem_addr, dmem_wdata};
        else check({tag, ":dstable"}, {dmem_we, dmem_addr, dmem_wdata}, first);
        last_dreq++;
        d_we = dmem_we; d_addr = dmem_addr; d_wdata = dmem_wdata;
        if (left > 0) begin
          dmem_ack = 1'b0;
          left--;
        end else begin
          dmem_ack   = 1'b1;
          dmem_rdata = rd;
        end
      end else begin
        dmem_ack = 1'b0;
      end
      @(negedge clk);
      cyc++;
      guard++;
    end
    dmem_ack = 1'b0;
    check({tag, ":cyc"}, cyc, exp_cyc);
    check({tag, ":pc"}, pc, exp_q.pop_front());
    pc_m = exp_pc;
  endtask

  initial begin
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 16'h0000;
    dmem_ack   = 1'b0;
    dmem_rdata = 8'h00;
    dbg_sel    = 3'd0;
    pc_m       = 8'h00;

    // Reset state with imem_ack tied high
    for (int i = 0; i < 8; i++) chk_reg("rst_reg", 3'(i), 8'h00);
    check("rst_pc", pc, 8'h00);
    check("rst_state", state, 2'd0);
    check("rst_ireq", imem_req, 1'b1);
    check("rst_flags", flags, 4'h0);
    check("rst_dreq", dmem_req, 1'b0);
    imem_ack = 1'b0;
    reset    = 1'b0;

    // Build 0x7F, then 0x7F + 1 -> 0x80 with V and N set
    run_instr("dec",  enc(OP_DEC, 3'd1, 3'd0, 3'd0), 0, 0, 8'h00, 2, pc_m + 8'd1);
    run_instr("shr",  enc(OP_SHR, 3'd1, 3'd0, 3'd1), 0, 0, 8'h00, 2, pc_m + 8'd1);
    chk_reg("r1_7f", 3'd1, 8'h7F);
    run_instr("adi",  enc(OP_ADI, 3'd2, 3'd1, 3'd1), 0, 0, 8'h00, 2, pc_m + 8'd1);
    chk_reg("r2_80", 3'd2, 8'h80);
    check("flags_adi", flags, 4'b1010);

    // Load from 0x05 with three stalled data cycles
    run_instr("ldi",  enc(OP_LDI, 3'd3, 3'd0, 3'd5), 0, 0, 8'h00, 2, pc_m + 8'd1);
    run_instr("ld",   enc(OP_LD, 3'd4, 3'd3, 3'd0), 0, 3, 8'hA5, 6, pc_m + 8'd1);
    check("ld_dreq_cycles", last_dreq, 4);
    check("ld_addr", d_addr, 8'h05);
    check("ld_we", d_we, 1'b0);
    chk_reg("r4_a5", 3'd4, 8'hA5);
    check("flags_ld", flags, 4'b0000);

    // ALU op behind two fetch wait states: A5 + 80 = 25, V and C set
    run_instr("add",  enc(OP_ADD, 3'd5, 3'd4, 3'd2), 2, 0, 8'h00, 4, pc_m + 8'd1);
    chk_reg("r5_25", 3'd5, 8'h25);
    check("flags_add", flags, 4'b1100);

    // Store R4 to [R3]; flags must not move
    run_instr("st",   enc(OP_ST, 3'd0, 3'd3, 3'd4), 0, 0, 8'h00, 3, pc_m + 8'd1);
    check("st_dreq_cycles", last_dreq, 1);
    check("st_bus", {d_we, d_addr, d_wdata}, {1'b1, 8'h05, 8'hA5});
    check("flags_st", flags, 4'b1100);

    // Branch-zero on R0=0 while the Z flag is clear
    run_instr("adi7", enc(OP_ADI, 3'd7, 3'd0, 3'd3), 0, 0, 8'h00, 2, pc_m + 8'd1);
    check("flags_adi7", flags, 4'b0000);
    run_instr("jmp0", enc(OP_JMP, 3'd0, 3'd0, 3'd0), 0, 0, 8'h00, 2, 8'h00);
    run_instr("bz1",  enc(OP_BZ, 3'b111, 3'd0, 3'b110), 0, 0, 8'h00, 2, BZ1_PC);

    // Z flag set, then branch-negative on R2=0x80 while N flag is clear
    run_instr("sub",  enc(OP_SUB, 3'd6, 3'd1, 3'd1), 0, 0, 8'h00, 2, pc_m + 8'd1);
    chk_reg("r6_00", 3'd6, 8'h00);
    check("flags_sub", flags, 4'b0101);
    run_instr("bn",   enc(OP_BN, 3'b000, 3'd2, 3'b010), 0, 0, 8'h00, 2,
              BN_TAKEN ? pc_m + 8'd2 : pc_m + 8'd1);

    // Branch-zero on R7=3 while the Z flag is set
    run_instr("jmp0b", enc(OP_JMP, 3'd0, 3'd0, 3'd0), 0, 0, 8'h00, 2, 8'h00);
    run_instr("bz2",  enc(OP_BZ, 3'b111, 3'd7, 3'b110), 0, 0, 8'h00, 2, BZ2_PC);

    // Build 0x3C in R5 and jump there
    run_instr("ldi5", enc(OP_LDI, 3'd5, 3'd0, 3'd7), 0, 0, 8'h00, 2, pc_m + 8'd1);
    run_instr("adi5", enc(OP_ADI, 3'd5, 3'd5, 3'd7), 0, 0, 8'h00, 2, pc_m + 8'd1);
    run_instr("inc5", enc(OP_INC, 3'd5, 3'd5, 3'd0), 0, 0, 8'h00, 2, pc_m + 8'd1);
    run_instr("shl5a", enc(OP_SHL, 3'd5, 3'd0, 3'd5), 0, 0, 8'h00, 2, pc_m + 8'd1);
    run_instr("shl5b", enc(OP_SHL, 3'd5, 3'd0, 3'd5), 0, 0, 8'h00, 2, pc_m + 8'd1);
    chk_reg("r5_3c", 3'd5, 8'h3C);
    check("flags_shl", flags, 4'b0000);
    run_instr("jmp5", enc(OP_JMP, 3'd0, 3'd5, 3'd0), 0, 0, 8'h00, 2, 8'h3C);

    // HALT: no requests, PC frozen
    run_instr("halt", 16'hFE00, 0, 0, 8'h00, 2, 8'h3C);
    check("halt_state", state, 2'd3);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halt_idle", {halted, imem_req, dmem_req, pc}, {1'b1, 2'b00, 8'h3C});
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    // Reset leaves HALT and clears the machine
    reset = 1'b1;
    @(negedge clk);
    check("rst2_state", state, 2'd0);
    check("rst2_pc", pc, 8'h00);
    reset = 1'b0;
    pc_m  = 8'h00;
    run_instr("inc1", enc(OP_INC, 3'd1, 3'd0, 3'd0), 0, 0, 8'h00, 2, 8'h01);

    // Reset while a load waits in MEM
    imem_rdata = enc(OP_LD, 3'd4, 3'd1, 3'd0);
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("mrst_exec", state, 2'd1);
    @(negedge clk);
    check("mrst_mem", {state, dmem_req}, {2'd2, 1'b1});
    reset    = 1'b1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("mrst_after", {dmem_req, state, pc}, {1'b0, 2'd0, 8'h00});
    reset      = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 8'h77;
    @(negedge clk);
    check("stale_ack", {state, dmem_req}, {2'd0, 1'b0});
    dmem_ack = 1'b0;
    pc_m     = 8'h00;
    chk_reg("stale_r4", 3'd4, 8'h00);
    chk_reg("rst_r1", 3'd1, 8'h00);

    // Normal operation resumes; R0 is writable too
    run_instr("inc2", enc(OP_INC, 3'd2, 3'd0, 3'd0), 0, 0, 8'h00, 2, 8'h01);
    run_instr("ldi0", enc(OP_LDI, 3'd0, 3'd0, 3'd6), 0, 0, 8'h00, 2, 8'h02);
    chk_reg("r2_01", 3'd2, 8'h01);
    chk_reg("r0_06", 3'd0, 8'h06);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
